// File: rtl/codifica_hamming_tx.sv
// Hamming(15,11) transmitter: accepts 11-bit words over valid/ready, encodes
// them into the corrector's codeword layout and serializes each codeword
// LSB-first inside a start(0)/stop(1) frame. One-entry buffer allows
// back-to-back frames.
// Build option: define PARIDADE_GLOBAL_EN to append an overall even-parity
// bit after codeword bit 14 (18 bit-time frame instead of 17).
module codifica_hamming_tx #(
    parameter int CICLOS_POR_BIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] dado,
    input  logic        dado_valido,
    output logic        dado_pronto,
    output logic [14:0] palavra,
    output logic        serial_out,
    output logic        ocupado
);

`ifdef PARIDADE_GLOBAL_EN
    localparam int NBITS = 16;
`else
    localparam int NBITS = 15;
`endif

    localparam int              CW        = (CICLOS_POR_BIT > 1) ? $clog2(CICLOS_POR_BIT) : 1;
    localparam logic [CW-1:0]   CICLO_MAX = CW'(CICLOS_POR_BIT - 1);
    localparam logic [3:0]      BIT_MAX   = 4'(NBITS - 1);

    typedef enum logic [1:0] {OCIOSO, INICIO, DADOS, FIM} estado_t;

    // Codeword index i is Hamming position i+1; parity sits at 1,2,4,8.
    function automatic logic [14:0] codificar(input logic [10:0] d);
        logic [14:0] c;
        c       = '0;
        c[2]    = d[0];
        c[4]    = d[1];
        c[5]    = d[2];
        c[6]    = d[3];
        c[14:8] = d[10:4];
        c[0]    = ^{c[2], c[4], c[6], c[8], c[10], c[12], c[14]};
        c[1]    = ^{c[2], c[5], c[6], c[9], c[10], c[13], c[14]};
        c[3]    = ^{c[4], c[5], c[6], c[11], c[12], c[13], c[14]};
        c[7]    = ^c[14:8];
        return c;
    endfunction

    // Bits that go out between the start and stop bits, LSB first.
    function automatic logic [NBITS-1:0] quadro(input logic [14:0] cw);
`ifdef PARIDADE_GLOBAL_EN
        return {^cw, cw};
`else
        return cw;
`endif
    endfunction

    estado_t          estado_q, estado_d;
    logic [CW-1:0]    ciclo_q, ciclo_d;
    logic [3:0]       bit_q, bit_d;
    logic [NBITS-1:0] desloc_q, desloc_d;
    logic [14:0]      buf_q, buf_d;
    logic             cheio_q, cheio_d;
    logic [14:0]      palavra_q, palavra_d;
    logic             fim_bit;

    // State register: FSM, counters, shift register, buffer and parallel tap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q  <= OCIOSO;
            ciclo_q   <= '0;
            bit_q     <= '0;
            desloc_q  <= '0;
            buf_q     <= '0;
            cheio_q   <= 1'b0;
            palavra_q <= '0;
        end else begin
            estado_q  <= estado_d;
            ciclo_q   <= ciclo_d;
            bit_q     <= bit_d;
            desloc_q  <= desloc_d;
            buf_q     <= buf_d;
            cheio_q   <= cheio_d;
            palavra_q <= palavra_d;
        end
    end

    assign fim_bit = (ciclo_q == CICLO_MAX);

    // Next state: frame sequencing, buffer load into the shifter, and accept.
    always_comb begin
        estado_d  = estado_q;
        ciclo_d   = ciclo_q;
        bit_d     = bit_q;
        desloc_d  = desloc_q;
        buf_d     = buf_q;
        cheio_d   = cheio_q;
        palavra_d = palavra_q;

        if (estado_q != OCIOSO)
            ciclo_d = fim_bit ? '0 : ciclo_q + CW'(1);

        case (estado_q)
            OCIOSO: begin
                if (cheio_q) begin
                    desloc_d = quadro(buf_q);
                    cheio_d  = 1'b0;
                    estado_d = INICIO;
                    ciclo_d  = '0;
                    bit_d    = '0;
                end
            end
            INICIO: begin
                if (fim_bit)
                    estado_d = DADOS;
            end
            DADOS: begin
                if (fim_bit) begin
                    desloc_d = desloc_q >> 1;
                    if (bit_q == BIT_MAX) begin
                        bit_d    = '0;
                        estado_d = FIM;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            FIM: begin
                // A waiting word starts right after the stop bit, no idle gap.
                if (fim_bit) begin
                    if (cheio_q) begin
                        desloc_d = quadro(buf_q);
                        cheio_d  = 1'b0;
                        estado_d = INICIO;
                        bit_d    = '0;
                    end else begin
                        estado_d = OCIOSO;
                    end
                end
            end
            default: estado_d = OCIOSO;
        endcase

        // Accept only into an empty buffer, so never in the same cycle as a load.
        if (dado_valido && !cheio_q) begin
            buf_d     = codificar(dado);
            palavra_d = codificar(dado);
            cheio_d   = 1'b1;
        end
    end

    // Outputs: line level from the FSM state, handshake and busy from registers.
    always_comb begin
        serial_out = 1'b1;
        case (estado_q)
            OCIOSO:  serial_out = 1'b1;
            INICIO:  serial_out = 1'b0;
            DADOS:   serial_out = desloc_q[0];
            FIM:     serial_out = 1'b1;
            default: serial_out = 1'b1;
        endcase
        dado_pronto = !cheio_q;
        ocupado     = (estado_q != OCIOSO) || cheio_q;
        palavra     = palavra_q;
    end

endmodule

// File: tb/tb_codifica_hamming_tx.sv
module tb_codifica_hamming_tx;

`ifdef PARIDADE_GLOBAL_EN
    localparam int CPB = 1;
    localparam int NB  = 16;
`else
    localparam int CPB = 4;
    localparam int NB  = 15;
`endif
    localparam int FR   = NB + 2;
    localparam int LIM  = 4 * FR * CPB + 10;

    logic        clk, rst;
    logic [10:0] dado;
    logic        dado_valido, dado_pronto, serial_out, ocupado;
    logic [14:0] palavra;

    codifica_hamming_tx #(.CICLOS_POR_BIT(CPB)) dut (
        .clk(clk), .rst(rst), .dado(dado), .dado_valido(dado_valido),
        .dado_pronto(dado_pronto), .palavra(palavra),
        .serial_out(serial_out), .ocupado(ocupado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0, n_fail = 0;

    function automatic void chk(input string tag, input bit ok);
        n_chk++;
        if (ok) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s", tag);
        end
    endfunction

    typedef struct { logic [14:0] cw; logic [10:0] d; } esp_t;
    esp_t sb[$];

    function automatic logic [14:0] enc(input logic [10:0] d);
        logic [14:0] c;
        int k;
        c = '0; k = 0;
        for (int p = 1; p <= 15; p++)
            if ((p & (p - 1)) != 0) begin c[p-1] = d[k]; k++; end
        for (int j = 0; j < 4; j++) begin
            logic x;
            x = 1'b0;
            for (int p = 1; p <= 15; p++)
                if (((p >> j) & 1) == 1 && p != (1 << j)) x ^= c[p-1];
            c[(1 << j) - 1] = x;
        end
        return c;
    endfunction

    function automatic logic [10:0] dec(input logic [14:0] cw);
        logic [14:0] c;
        logic [10:0] d;
        int s, k;
        c = cw; s = 0; k = 0; d = '0;
        for (int p = 1; p <= 15; p++) if (c[p-1]) s ^= p;
        if (s != 0) c[s-1] = ~c[s-1];
        for (int p = 1; p <= 15; p++)
            if ((p & (p - 1)) != 0) begin d[k] = c[p-1]; k++; end
        return d;
    endfunction

    int cyc = 0, acc_cyc = 0;
    always @(posedge clk) begin
        cyc++;
        if (!rst && dado_valido && dado_pronto) begin
            sb.push_back('{enc(dado), dado});
            acc_cyc = cyc;
        end
    end

    bit          m_act = 0;
    int          m_pos, idx, ph, start_cyc = 0, stop_cyc = 0, gap = 0, flip;
    logic [15:0] m_bits;
    logic        bexp;
    esp_t        e;
    always @(negedge clk) begin
        if (rst) begin
            m_act = 0;
        end else if (!m_act) begin
            if (serial_out === 1'b0) begin
                chk("frame_expected", sb.size() > 0);
                if (sb.size() > 0) begin
                    e         = sb.pop_front();
                    m_act     = 1;
                    m_pos     = 1;
                    m_bits    = '0;
                    gap       = cyc - stop_cyc;
                    start_cyc = cyc;
                end
            end
        end else begin
            idx = m_pos / CPB;
            ph  = m_pos % CPB;
            if (idx == 0) begin
                chk("start_bit", serial_out === 1'b0);
            end else if (idx <= NB) begin
                if (idx - 1 < 15) bexp = e.cw[idx-1];
                else              bexp = ^e.cw;
                if (ph == 0) m_bits[idx-1] = serial_out;
                chk("data_bit", serial_out === bexp);
            end else begin
                chk("stop_bit", serial_out === 1'b1);
                if (ph == CPB - 1) begin
                    m_act    = 0;
                    stop_cyc = cyc;
                    chk("frame_word", m_bits[14:0] === e.cw);
                    flip = $urandom_range(0, 14);
                    chk("round_trip", dec(m_bits[14:0] ^ (15'd1 << flip)) === e.d);
                end
            end
            m_pos++;
        end
    end

    task automatic enviar(input logic [10:0] d);
        int t;
        @(negedge clk);
        dado = d;
        dado_valido = 1'b1;
        t = 0;
        while (!dado_pronto && t < LIM) begin @(negedge clk); t++; end
        chk("accept_ready", dado_pronto === 1'b1);
        @(posedge clk);
        #1;
        chk("palavra_model", palavra === enc(d));
        chk("pronto_low_full", dado_pronto === 1'b0);
        chk("ocupado_full", ocupado === 1'b1);
        dado_valido = 1'b0;
    endtask

    task automatic drenar();
        int t;
        t = 0;
        while ((sb.size() != 0 || ocupado) && t < LIM) begin @(negedge clk); t++; end
        chk("drain_idle", ocupado === 1'b0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; dado = '0; dado_valido = 1'b0;
        #1;
        chk("rst_serial", serial_out === 1'b1);
        chk("rst_pronto", dado_pronto === 1'b1);
        chk("rst_ocupado", ocupado === 1'b0);
        chk("rst_palavra", palavra === 15'h0000);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        enviar(11'h000);
        chk("enc_000", palavra === 15'h0000);
        drenar();
        enviar(11'h7FF);
        chk("enc_7FF", palavra === 15'h7FFF);
        drenar();

        enviar(11'h001);
        chk("enc_001", palavra === 15'h0007);
        repeat (FR * CPB) @(posedge clk);
        #1;
        chk("last_stop_ocupado", ocupado === 1'b1);
        chk("last_stop_serial", serial_out === 1'b1);
        @(posedge clk);
        #1;
        chk("after_frame_ocupado", ocupado === 1'b0);
        chk("after_frame_serial", serial_out === 1'b1);
        chk("start_latency", start_cyc === acc_cyc + 1);
        chk("palavra_held", palavra === 15'h0007);

        enviar(11'h7FF);
        enviar(11'h2AA);
        repeat (3) begin
            @(negedge clk);
            chk("pronto_low_b2b", dado_pronto === 1'b0);
        end
        drenar();
        chk("b2b_gap", gap === 1);
        chk("b2b_palavra", palavra === enc(11'h2AA));

        enviar(11'h155);
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_serial", serial_out === 1'b1);
        chk("midrst_pronto", dado_pronto === 1'b1);
        chk("midrst_ocupado", ocupado === 1'b0);
        chk("midrst_palavra", palavra === 15'h0000);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sb.delete();
        enviar(11'h3C3);
        drenar();

        for (int i = 0; i < 1000; i++) enviar(11'($urandom_range(0, 2047)));
        drenar();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/codifica_hamming_tx.md
Name: codifica_hamming_tx

Overview:
Transmit-side partner of the Hamming(15,11) corrector. Accepts 11-bit data words over a valid/ready handshake and encodes each into a 15-bit Hamming codeword using the same bit layout the corrector expects. Serializes each codeword LSB-first on a single line inside a start/stop frame. Sits between the data producer and the serial link whose far end feeds the corrector.

Parameters:
CICLOS_POR_BIT, 4, clock cycles each serial bit is held; legal range >= 1.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
dado  input  11  data word d1..d11 (dado[0] = d1).
dado_valido  input  1  producer has a word on dado.
dado_pronto  output  1  block can accept a word this cycle.
palavra  output  15  codeword of the most recently accepted word (debug/parallel tap).
serial_out  output  1  serial line; idles high.
ocupado  output  1  high while a frame is on the line or a word is buffered.

Behaviour:
- Reset (async, immediate): serial_out=1, dado_pronto=1, ocupado=0, palavra=0, buffer empty, FSM=OCIOSO, bit and cycle counters=0. A frame in flight when reset asserts is discarded. No partial frame resumes after reset.
- Codeword index i holds Hamming position i+1.
- Data mapping: dado[0]->idx2, dado[1]->idx4, dado[2]->idx5, dado[3]->idx6, dado[10:4]->idx14:8.
- Parity bits (even):
  - idx0 = ^{idx2,4,6,8,10,12,14}
  - idx1 = ^{idx2,5,6,9,10,13,14}
  - idx3 = ^{idx4,5,6,11,12,13,14}
  - idx7 = ^{idx8..14}
- Handshake:
  - A transfer occurs on a rising edge with dado_valido=1 and dado_pronto=1.
  - dado_pronto = buffer empty; it is a registered state, not combinational from dado_valido.
  - On transfer, the codeword is computed combinationally and latched into a one-entry buffer and into palavra.
  - While the buffer is full, dado is ignored.
- FSM states:
  - OCIOSO: serial_out=1. Buffer full -> load shift register from buffer, empty the buffer, go to INICIO next edge. A word accepted at edge N while idle is loaded at edge N+1.
  - INICIO: serial_out=0 for CICLOS_POR_BIT cycles -> DADOS.
  - DADOS: serial_out = codeword bit k, k=0..14, each for CICLOS_POR_BIT cycles -> FIM after bit 14.
  - FIM: serial_out=1 for CICLOS_POR_BIT cycles. At the end of the last FIM cycle: buffer full -> load and go directly to INICIO (no idle gap); else -> OCIOSO.
- Buffering:
  - The buffer may be refilled while a frame is transmitting, once its previous contents were loaded into the shift register. This allows back-to-back frames.
  - Load and accept in the same cycle are impossible, because dado_pronto is low while the buffer is full.
- Frame timing: 17 bit-times (17*CICLOS_POR_BIT cycles).
- Cycle counter: counts 0..CICLOS_POR_BIT-1 and wraps. With CICLOS_POR_BIT=1, each bit lasts exactly one cycle.
- ocupado = (FSM != OCIOSO) | buffer full.
- palavra changes only on a transfer; it is unaffected by serialization.

Optional Feature:
PARIDADE_GLOBAL_EN
- Defined: after codeword bit 14, transmit one extra bit equal to the XOR of all 15 codeword bits (overall even parity, SECDED framing). Frame becomes 18 bit-times. palavra stays 15 bits.
- Undefined: no extra bit; 17 bit-time frame exactly as above.

Test Plan:
- Reset: assert rst mid-frame -> serial_out=1, dado_pronto=1, ocupado=0, palavra=0 immediately, without waiting for a clock edge; the next accepted word produces a clean full frame.
- Encoding: dado=11'h000 -> palavra=15'h0000; dado=11'h001 -> palavra=15'h0007; dado=11'h7FF -> palavra=15'h7FFF. Feed each palavra to the corrector -> output equals dado.
- Serial timing, CICLOS_POR_BIT=4: accept 11'h001 at edge 0 ->
  - serial_out=0 for cycles 1-4 (start bit);
  - bits 1,1,1 for cycles 5-16;
  - bits 0 for cycles 17-64;
  - 1 for cycles 65-68 (stop bit);
  - then idle high; ocupado falls after cycle 68.
- Back-to-back: offer 11'h7FF then 11'h2AA continuously -> second word accepted during the first frame; second start bit immediately follows the first stop bit; dado_pronto low while the buffer is full.
- Round trip: random 11-bit words through serial capture plus the corrector, with a single-bit flip injected per codeword -> recovered data matches, 1000 words.
- CICLOS_POR_BIT=1, and PARIDADE_GLOBAL_EN defined: dado=11'h001 -> 18-cycle frame whose 17th bit is 1.
